nanov_sequencer: RTL and testbench

//  Instruction sequencer for the bit-serial nanoV core. Fetches 32-bit words over a req/ack port into
//  a one-deep prefetch buffer. Drives instr/next_instr/cycle/counter and a serial PC bit, and gates the

---
 rtl/nanov_pkg.sv | 44 ++++
 rtl/nanov_prefetch_buf.sv | 40 ++++
 rtl/nanov_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_nanov_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/nanov_pkg.sv
// ============================================================================
// Module : nanov_pkg
// Brief  : Opcode constants, sequencer state encoding and sub-cycle lookup
//          shared by the nanoV instruction sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nanov_pkg;

   localparam logic [4:0] c_opc_op     = 5'b01100;
   localparam logic [4:0] c_opc_op_imm = 5'b00100;
   localparam logic [4:0] c_opc_lui    = 5'b01101;
   localparam logic [4:0] c_opc_auipc  = 5'b00101;
   localparam logic [4:0] c_opc_jal    = 5'b11011;
   localparam logic [4:0] c_opc_jalr   = 5'b11001;
   localparam logic [4:0] c_opc_branch = 5'b11000;
   localparam logic [4:0] c_opc_load   = 5'b00000;
   localparam logic [4:0] c_opc_store  = 5'b01000;

   typedef enum logic [1:0] {
      ST_FETCH_WAIT = 2'd0,
      ST_EXEC       = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } state_t;

   // Number of 32-bit sub-cycles the core needs for an instruction.
   function automatic logic [2:0] sub_cycles(input logic [4:0] opcode,
                                             input logic [2:0] funct3);
      logic [2:0] n;
      n = 3'd1;
      case (opcode)
         c_opc_op, c_opc_op_imm:
            if (funct3 == 3'b001 || funct3 == 3'b101) n = 3'd2;
         c_opc_jal, c_opc_jalr, c_opc_branch: n = 3'd2;
         c_opc_load, c_opc_store:             n = 3'd2;
         default:                             n = 3'd1;
      endcase
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nanov_prefetch_buf.sv
// ============================================================================
// Module : nanov_prefetch_buf
// Brief  : One-entry instruction prefetch buffer with load, take and flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nanov_prefetch_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic        take,
   input  logic        flush,
   output logic        valid,
   output logic [31:0] data
);

   logic        r_valid;
   logic [31:0] r_data;

   // Flush beats load so a redirect also discards a same-cycle fetch word.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid <= 1'b0;
         r_data  <= 32'd0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_data  <= load_data;
      end else if (take) begin
         r_valid <= 1'b0;
      end
   end

   assign valid = r_valid;
   assign data  = r_data;

endmodule

`default_nettype wire

// File: rtl/nanov_sequencer.sv
// ============================================================================
// Module : nanov_sequencer
// Brief  : Fetch, sub-cycle sequencing, branch redirect and load/store
//          handshake for the bit-serial nanoV core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nanov_sequencer
   import nanov_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_ack,
   input  logic [31:0] fetch_data,
   output logic        core_en,
   output logic [31:0] instr,
   output logic [30:0] next_instr,
   output logic [2:0]  cycle,
   output logic [4:0]  counter,
   output logic        pc,
   input  logic        branch,
   input  logic [31:0] branch_target,
   output logic        shift_data_out,
   output logic        mem_req,
   output logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        load_bit
);

   localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

   state_t      r_state, w_next_state;
   logic [31:0] r_instr;
   logic [4:0]  r_counter;
   logic [2:0]  r_cycle;
   logic [31:0] r_pc;
   logic [31:0] r_fetch_pc;
   logic        r_branch_pend;
   logic [31:0] r_ld;
   logic [31:0] r_mem_addr;

   logic        w_buf_valid;
   logic [31:0] w_buf_data;
   logic [2:0]  w_ncyc;
   logic        w_is_load, w_is_store;
   logic        w_last, w_final, w_stall, w_core_en, w_redirect;
   logic        w_retire, w_mem_enter;
   logic        w_slot_free, w_flush, w_to_instr, w_buf_load, w_buf_take, w_accept;
   logic [31:0] w_target;
   logic        w_unused;

   assign w_ncyc     = sub_cycles(r_instr[6:2], r_instr[14:12]);
   assign w_is_load  = (r_instr[6:2] == c_opc_load);
   assign w_is_store = (r_instr[6:2] == c_opc_store);
   assign w_last     = (r_counter == 5'd31);
   assign w_final    = (r_cycle == (w_ncyc - 3'd1));
   assign w_target   = {branch_target[31:2], 2'b00};

   // A store's last bit leads into the memory wait, so it never stalls here.
   assign w_stall    = w_last && w_final && !w_is_store && !w_buf_valid && !r_branch_pend;
   assign w_core_en  = (r_state == ST_EXEC) && !w_stall;
   assign w_redirect = r_branch_pend || (branch && w_core_en);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_FETCH_WAIT;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_retire     = 1'b0;
      w_mem_enter  = 1'b0;
      case (r_state)
         ST_FETCH_WAIT: begin
            if (fetch_ack) w_next_state = ST_EXEC;
         end
         ST_EXEC: begin
            if (w_core_en && w_last) begin
               if ((w_is_load && r_cycle == 3'd0) || (w_is_store && w_final)) begin
                  w_mem_enter  = 1'b1;
                  w_next_state = ST_MEM_WAIT;
               end else if (w_final) begin
                  w_retire     = 1'b1;
                  w_next_state = w_redirect ? ST_FETCH_WAIT : ST_EXEC;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ack) begin
               if (w_is_store) begin
                  // Store retires here; with nothing buffered it refetches.
                  w_retire     = 1'b1;
                  w_next_state = (!w_redirect && (w_buf_valid || fetch_ack))
                                 ? ST_EXEC : ST_FETCH_WAIT;
               end else begin
                  w_next_state = ST_EXEC;
               end
            end
         end
         default: w_next_state = ST_FETCH_WAIT;
      endcase
   end

   assign w_slot_free = (r_state == ST_FETCH_WAIT) || !w_buf_valid;
   assign w_flush     = w_retire && w_redirect;
   assign w_accept    = fetch_ack && w_slot_free && !w_flush;
   assign w_to_instr  = w_accept && ((r_state == ST_FETCH_WAIT) || (w_retire && !w_buf_valid));
   assign w_buf_load  = w_accept && !w_to_instr;
   assign w_buf_take  = w_retire && !w_redirect && w_buf_valid;

   nanov_prefetch_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (w_buf_load),
      .load_data (fetch_data),
      .take      (w_buf_take),
      .flush     (w_flush),
      .valid     (w_buf_valid),
      .data      (w_buf_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr       <= 32'd0;
         r_counter     <= 5'd0;
         r_cycle       <= 3'd0;
         r_pc          <= c_reset_pc;
         r_fetch_pc    <= c_reset_pc;
         r_branch_pend <= 1'b0;
         r_ld          <= 32'd0;
         r_mem_addr    <= 32'd0;
      end else begin
         if (w_flush)       r_fetch_pc <= w_target;
         else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;

         if (w_retire)                 r_branch_pend <= 1'b0;
         else if (w_core_en && branch) r_branch_pend <= 1'b1;

         if (w_retire) r_pc <= w_redirect ? w_target : r_pc + 32'd4;

         if (w_to_instr)      r_instr <= fetch_data;
         else if (w_buf_take) r_instr <= w_buf_data;

         if (r_state != ST_EXEC) r_counter <= 5'd0;
         else if (w_core_en)     r_counter <= r_counter + 5'd1;

         if (w_retire || r_state == ST_FETCH_WAIT)  r_cycle <= 3'd0;
         else if (w_core_en && w_last && !w_final)  r_cycle <= r_cycle + 3'd1;

         if (r_state == ST_MEM_WAIT && mem_ack && w_is_load) r_ld <= mem_rdata;
         if (w_mem_enter) r_mem_addr <= mem_addr;
      end
   end

   // The captured address and the target's byte offset are not consumed here.
   assign w_unused = ^{branch_target[1:0], r_mem_addr};

   assign fetch_req      = !rst && w_slot_free;
   assign fetch_addr     = r_fetch_pc;
   assign core_en        = w_core_en;
   assign instr          = r_instr;
   assign next_instr     = w_buf_valid ? w_buf_data[30:0] : 31'd0;
   assign cycle          = r_cycle;
   assign counter        = r_counter;
   assign pc             = r_pc[r_counter];
   assign shift_data_out = (r_state == ST_EXEC) && w_is_store && (r_cycle == 3'd1);
   assign mem_req        = (r_state == ST_MEM_WAIT);
   assign mem_we         = (r_state == ST_MEM_WAIT) && w_is_store;
   assign load_bit       = (r_state == ST_EXEC) && w_is_load && (r_cycle == 3'd1)
                           && r_ld[r_counter];

endmodule

`default_nettype wire

// File: tb/tb_nanov_sequencer.sv
// ============================================================================
// Module : tb_nanov_sequencer
// Brief  : Directed self-checking bench for the nanoV instruction sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nanov_sequencer;

   localparam logic [31:0] c_addi = 32'h0010_0093;
   localparam logic [31:0] c_add  = 32'h0010_8133;
   localparam logic [31:0] c_jal  = 32'h0000_00EF;
   localparam logic [31:0] c_sw   = 32'h0020_2023;
   localparam logic [31:0] c_lw   = 32'h0000_2183;
   localparam logic [31:0] c_lw2  = 32'h0000_2203;
   localparam logic [31:0] c_nop  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack;
   logic [31:0] fetch_data;
   logic        core_en;
   logic [31:0] instr;
   logic [30:0] next_instr;
   logic [2:0]  cycle;
   logic [4:0]  counter;
   logic        pc;
   logic        branch;
   logic [31:0] branch_target;
   logic        shift_data_out;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        load_bit;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] acc;
   int          shcount;

   nanov_sequencer #(.RESET_PC(32'h0000_0100)) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_req      (fetch_req),
      .fetch_addr     (fetch_addr),
      .fetch_ack      (fetch_ack),
      .fetch_data     (fetch_data),
      .core_en        (core_en),
      .instr          (instr),
      .next_instr     (next_instr),
      .cycle          (cycle),
      .counter        (counter),
      .pc             (pc),
      .branch         (branch),
      .branch_target  (branch_target),
      .shift_data_out (shift_data_out),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .load_bit       (load_bit)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; fetch_ack = 1'b0; fetch_data = 32'd0; branch = 1'b0;
      branch_target = 32'd0; mem_addr = 32'h0000_0040; mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (3) tick();
      chk("rst_core_en",   {31'd0, core_en},   32'd0);
      chk("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
      chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
      chk("rst_instr",     instr,              32'd0);
      chk("rst_counter",   {27'd0, counter},   32'd0);
      rst = 1'b0;
      #1;
      chk("t1_fetch_req",  {31'd0, fetch_req}, 32'd1);
      chk("t1_fetch_addr", fetch_addr,         32'h0000_0100);

      // Test 1: ADDI then ADD, zero-bubble retire.
      fetch_ack = 1'b1; fetch_data = c_addi; tick(); fetch_ack = 1'b0;
      chk("t1_instr_addi", instr,              c_addi);
      chk("t1_core_en",    {31'd0, core_en},   32'd1);
      chk("t1_fetch_addr2", fetch_addr,        32'h0000_0104);
      fetch_ack = 1'b1; fetch_data = c_add; tick(); fetch_ack = 1'b0;
      chk("t1_next_instr", {1'b0, next_instr}, c_add & 32'h7FFF_FFFF);
      repeat (30) tick();
      chk("t1_counter31",  {27'd0, counter},   32'd31);
      chk("t1_en_last",    {31'd0, core_en},   32'd1);
      tick();
      chk("t1_instr_add",  instr,              c_add);
      chk("t1_counter0",   {27'd0, counter},   32'd0);

      // Test 2: starved fetch port stalls at the last bit.
      acc = 32'd0;
      for (int i = 0; i < 32; i++) begin
         acc[counter] = pc;
         if (i != 31) tick();
      end
      chk("t1_pc_q",       acc,                32'h0000_0104);
      chk("t2_stall_en",   {31'd0, core_en},   32'd0);
      tick(); tick();
      chk("t2_hold_cnt",   {27'd0, counter},   32'd31);
      chk("t2_hold_en",    {31'd0, core_en},   32'd0);
      chk("t2_hold_instr", instr,              c_add);
      fetch_ack = 1'b1; fetch_data = c_jal; tick(); fetch_ack = 1'b0;
      chk("t2_resume_en",  {31'd0, core_en},   32'd1);
      tick();
      chk("t2_instr_jal",  instr,              c_jal);
      chk("t2_fetch_addr", fetch_addr,         32'h0000_010C);

      // Test 3: JAL with branch pulse redirects to 0x200 at retire.
      branch = 1'b1; branch_target = 32'h0000_0200; tick(); branch = 1'b0;
      fetch_ack = 1'b1; fetch_data = c_nop; tick(); fetch_ack = 1'b0;
      chk("t3_buffered",   {1'b0, next_instr}, c_nop & 32'h7FFF_FFFF);
      repeat (61) tick();
      chk("t3_cycle1",     {29'd0, cycle},     32'd1);
      chk("t3_counter31",  {27'd0, counter},   32'd31);
      chk("t3_en",         {31'd0, core_en},   32'd1);
      tick();
      chk("t3_fw_en",      {31'd0, core_en},   32'd0);
      chk("t3_fetch_addr", fetch_addr,         32'h0000_0200);
      chk("t3_fetch_req",  {31'd0, fetch_req}, 32'd1);
      chk("t3_buf_flush",  {1'b0, next_instr}, 32'd0);

      // Test 4: store shifts rs2 for a full sub-cycle then waits on memory.
      fetch_ack = 1'b1; fetch_data = c_sw; tick();
      chk("t4_instr_sw",   instr,              c_sw);
      fetch_data = c_lw; tick(); fetch_ack = 1'b0;
      repeat (31) tick();
      chk("t4_cycle1",     {29'd0, cycle},     32'd1);
      shcount = 0; acc = 32'd0;
      for (int i = 0; i < 32; i++) begin
         shcount += int'(shift_data_out);
         acc[counter] = pc;
         if (i != 31) tick();
      end
      chk("t4_shift_cnt",  shcount,            32'd32);
      chk("t3_pc_q",       acc,                32'h0000_0200);
      tick();
      chk("t4_mem_req",    {31'd0, mem_req},   32'd1);
      chk("t4_mem_we",     {31'd0, mem_we},    32'd1);
      chk("t4_mw_en",      {31'd0, core_en},   32'd0);
      chk("t4_mw_shift",   {31'd0, shift_data_out}, 32'd0);
      repeat (4) tick();
      chk("t4_mem_hold",   {31'd0, mem_req},   32'd1);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      chk("t4_retire_req", {31'd0, mem_req},   32'd0);
      chk("t4_instr_lw",   instr,              c_lw);
      chk("t4_en",         {31'd0, core_en},   32'd1);
      chk("t4_fetch_addr", fetch_addr,         32'h0000_0208);

      // Test 5: load data replayed serially in cycle 1.
      fetch_ack = 1'b1; fetch_data = c_lw2; tick(); fetch_ack = 1'b0;
      repeat (30) tick();
      chk("t5_counter31",  {27'd0, counter},   32'd31);
      tick();
      chk("t5_mem_req",    {31'd0, mem_req},   32'd1);
      chk("t5_mem_we",     {31'd0, mem_we},    32'd0);
      chk("t5_cycle1",     {29'd0, cycle},     32'd1);
      mem_rdata = 32'hA5A5_0F0F; mem_ack = 1'b1; tick(); mem_ack = 1'b0; mem_rdata = 32'd0;
      chk("t5_en",         {31'd0, core_en},   32'd1);
      acc = 32'd0;
      for (int i = 0; i < 32; i++) begin
         acc[counter] = load_bit;
         if (i != 31) tick();
      end
      chk("t5_load_bits",  acc,                32'hA5A5_0F0F);
      tick();
      chk("t5_instr_lw2",  instr,              c_lw2);

      // Test 6: reset during a memory wait drops the access.
      repeat (32) tick();
      chk("t6_mem_req",    {31'd0, mem_req},   32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; tick(); mem_ack = 1'b0;
      chk("t6_mem_req0",   {31'd0, mem_req},   32'd0);
      chk("t6_core_en",    {31'd0, core_en},   32'd0);
      chk("t6_instr",      instr,              32'd0);
      chk("t6_fetch_addr", fetch_addr,         32'h0000_0100);
      chk("t6_fetch_req",  {31'd0, fetch_req}, 32'd1);
      chk("t6_counter",    {27'd0, counter},   32'd0);
      repeat (3) tick();
      chk("t6_still_fw",   {31'd0, core_en},   32'd0);
      chk("t6_load_bit",   {31'd0, load_bit},  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
